// File: rtl/step_pkg.sv
// Shared encodings for the step scheduler slice.
// State, grant and direction constants.
package step_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    GR_MAN  = 1'b0,
    GR_AUTO = 1'b1
  } grant_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/step_scheduler_rate_timer.sv
// Free-running rate timer for auto steps.
// Pulses tick at terminal count, held at 0 when disabled.
module rate_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int TW       = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Merges manual and auto step requests into one
// rate-limited step pulse stream for the counter.
module step_scheduler
  import step_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int TW       = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic man_p,
  input  logic man_dir,
  input  logic run_p,
  input  logic auto_dir,
  output logic inc_p,
  output logic UHDL,
  output logic running,
  output logic dropped
);

  state_t state;
  grant_t last_grant;
  grant_t sel;
  logic   cool;
  logic   man_v;
  logic   man_d;
  logic   auto_v;
  logic   auto_d;
  logic   tick;
  logic   gnt;
  logic   man_clr;
  logic   auto_clr;

  rate_timer #(
    .TICK_DIV(TICK_DIV),
    .TW      (TW)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .en   (state == ST_RUN),
    .tick (tick)
  );

  assign running = (state == ST_RUN);
  assign gnt     = !cool && (man_v || auto_v);

  // Round-robin only matters when both slots compete.
  always_comb begin
    sel = last_grant;
    unique case (1'b1)
      man_v && auto_v:
        sel = (last_grant == GR_MAN) ? GR_AUTO : GR_MAN;
      man_v && !auto_v:
        sel = GR_MAN;
      auto_v && !man_v:
        sel = GR_AUTO;
      default:
        sel = last_grant;
    endcase
  end

  assign man_clr  = gnt && (sel == GR_MAN);
  assign auto_clr = gnt && (sel == GR_AUTO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= GR_AUTO;
      cool       <= 1'b0;
      man_v      <= 1'b0;
      man_d      <= DIR_DN;
      auto_v     <= 1'b0;
      auto_d     <= DIR_DN;
      inc_p      <= 1'b0;
      UHDL       <= DIR_DN;
      dropped    <= 1'b0;
    end else begin
      if (run_p) begin
        state <= (state == ST_RUN) ? ST_IDLE : ST_RUN;
      end

      inc_p <= gnt;
      cool  <= gnt;
      if (gnt) begin
        UHDL       <= (sel == GR_AUTO) ? auto_d : man_d;
        last_grant <= sel;
      end

      // A slot being granted this cycle may be refilled.
      if (man_p) begin
        if (man_v && !man_clr) begin
          dropped <= 1'b1;
        end else begin
          man_v <= 1'b1;
          man_d <= man_dir;
        end
      end else if (man_clr) begin
        man_v <= 1'b0;
      end

      if (tick) begin
        if (auto_v && !auto_clr) begin
          dropped <= 1'b1;
        end else begin
          auto_v <= 1'b1;
          auto_d <= auto_dir;
        end
      end else if (auto_clr) begin
        auto_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench for step_scheduler.
// Expected pulses are queued as stimulus is driven.
module tb_step_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic man_p;
  logic man_dir;
  logic run_p;
  logic auto_dir;
  logic inc_p;
  logic UHDL;
  logic running;
  logic dropped;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic prev_inc = 1'b0;

  typedef struct {
    int   c;
    logic d;
  } exp_t;

  exp_t sb[$];

  step_scheduler #(
    .TICK_DIV(4),
    .TW      (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .man_p   (man_p),
    .man_dir (man_dir),
    .run_p   (run_p),
    .auto_dir(auto_dir),
    .inc_p   (inc_p),
    .UHDL    (UHDL),
    .running (running),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  // Pulse monitor: every inc_p must match the head of the scoreboard.
  always @(negedge clk) begin
    if (inc_p === 1'b1) begin
      check("b2b", 32'(prev_inc), 0);
      if (sb.size() == 0) begin
        check("unexp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pcyc", cyc, e.c);
        check("pdir", 32'(UHDL), 32'(e.d));
      end
    end
    prev_inc = (inc_p === 1'b1);
  end

  task automatic to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int c, logic d);
    exp_t e;
    e.c = c;
    e.d = d;
    sb.push_back(e);
  endtask

  // Drive one-cycle pulses sampled at edge e.
  task automatic man_at(int e, logic d);
    to(e - 1);
    man_p   = 1'b1;
    man_dir = d;
    to(e);
    man_p   = 1'b0;
  endtask

  task automatic run_at(int e, logic d);
    to(e - 1);
    run_p    = 1'b1;
    auto_dir = d;
    to(e);
    run_p    = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    man_p    = 1'b1;
    man_dir  = 1'b1;
    run_p    = 1'b0;
    auto_dir = 1'b0;

    for (int c = 1; c <= 3; c++) begin
      to(c);
      check("rst_out", {inc_p, UHDL, running, dropped}, 0);
    end
    reset = 1'b1;
    man_p = 1'b0;

    push(11, 1'b1);
    man_at(10, 1'b1);
    to(12);
    check("man_low", 32'(inc_p), 0);

    push(25, 1'b0);
    push(29, 1'b0);
    push(33, 1'b0);
    run_at(20, 1'b0);
    to(21);
    check("run_on", 32'(running), 1);
    run_at(34, 1'b0);
    to(35);
    check("run_off", 32'(running), 0);

    // Auto tick captured at edge 44 alongside a manual request.
    push(45, 1'b1);
    push(47, 1'b0);
    run_at(40, 1'b0);
    man_at(44, 1'b1);
    run_at(46, 1'b0);

    push(51, 1'b0);
    man_at(50, 1'b0);

    push(57, 1'b1);
    push(59, 1'b0);
    run_at(52, 1'b1);
    man_at(56, 1'b0);
    run_at(58, 1'b1);
    to(59);
    check("drop_pre", 32'(dropped), 0);

    push(63, 1'b1);
    push(65, 1'b0);
    to(61);
    man_p   = 1'b1;
    man_dir = 1'b1;
    to(62);
    man_dir = 1'b0;
    to(63);
    man_dir = 1'b1;
    to(64);
    man_p   = 1'b0;
    to(65);
    check("drop_set", 32'(dropped), 1);
    to(69);
    check("drop_hold", 32'(dropped), 1);

    // Both slots full at cycle 74, then reset before the grant lands.
    run_at(70, 1'b1);
    man_at(74, 1'b1);
    to(74);
    check("mid_run", 32'(running), 1);
    reset = 1'b0;
    to(75);
    reset = 1'b1;
    check("mid_rst", {inc_p, running, dropped}, 0);
    to(77);
    check("mid_quiet", 32'(inc_p), 0);

    push(85, 1'b0);
    run_at(80, 1'b0);
    run_at(86, 1'b0);

    to(95);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/step_scheduler.md
Name: step_scheduler

Overview:
- Controller that sequences the up/down counter datapath.
- Merges two step requesters into a single step stream for the counter:
  - manual steps: debounced, edge-detected button pulse plus a direction switch;
  - auto steps: an internal run/stop rate timer.
- Outputs are a one-cycle step pulse `inc_p` and a direction level `UHDL`.
- Sits between the edge detector and the counter, in place of the direct wiring.

Parameters:
- `TICK_DIV`, default 100_000_000: clk cycles between auto steps (1 s at 100 MHz). Legal range ≥ 2.
- `TW`, default 27: timer width. Must satisfy 2^TW ≥ `TICK_DIV`.

Ports:
- `clk`       in   1  system clock; all logic on its rising edge.
- `reset`     in   1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `man_p`     in   1  manual step request, one-cycle pulse.
- `man_dir`   in   1  manual direction, sampled with `man_p` (1 = up, 0 = down).
- `run_p`     in   1  one-cycle pulse that toggles auto-run on/off.
- `auto_dir`  in   1  auto direction, sampled when the auto tick fires.
- `inc_p`     out  1  one-cycle step pulse to the counter.
- `UHDL`      out  1  direction to the counter; valid whenever `inc_p` = 1.
- `running`   out  1  1 while in the RUN state.
- `dropped`   out  1  sticky flag: a request was lost because its slot was full.

Behaviour:
- Reset (`reset` = 0 at a clk edge):
  - outputs: `inc_p`=0, `UHDL`=0, `running`=0, `dropped`=0;
  - internal: timer=0, both slots empty, `last_grant`=AUTO, cooldown=0.
  - Reset mid-operation discards pending requests without emitting a pulse.
- Run FSM:
  - States IDLE and RUN; `running` = (state == RUN), registered.
  - `run_p` in IDLE → RUN; `run_p` in RUN → IDLE.
  - In IDLE the timer is held at 0.
  - In RUN the timer counts 0..`TICK_DIV`-1. When it equals `TICK_DIV`-1 it raises an auto request (with `auto_dir`) and wraps to 0.
  - The first auto request therefore arrives `TICK_DIV` cycles after entering RUN.
  - A tick coinciding with `run_p` in RUN is still captured; the state goes IDLE and the timer clears.
  - Leaving RUN does not flush an already-pending auto slot.
- Request slots:
  - One manual slot {valid, dir} and one auto slot {valid, dir}.
  - A new request into a full slot is dropped and sets `dropped` (sticky until reset).
  - A request arriving in the same cycle its slot is granted refills the slot; no drop.
- Issue / arbitration:
  - The grant is evaluated each cycle from slot state as it stands at the start of that cycle.
  - A grant is allowed only when cooldown = 0.
  - Only one slot valid: grant it.
  - Both slots valid: grant the slot opposite `last_grant` (round-robin, so neither requester starves).
  - On a grant, at the next edge:
    - `inc_p` = 1 and `UHDL` = granted slot's dir;
    - the slot is cleared, `last_grant` is updated, and cooldown is set to 1.
  - After a pulse, `inc_p` = 0 for at least one cycle; pulses are never back-to-back.
  - `UHDL` holds its last value between pulses.
- Latency: a request captured at edge n into an empty slot with no cooldown produces `inc_p` high in cycle n+1 (one registered stage).
- Sustained throughput: at most one step per 2 cycles.

Decomposition:
- Shared package `step_pkg` holds:
  - state encoding: `ST_IDLE` = 1'b0, `ST_RUN` = 1'b1;
  - grant encoding: `GR_MAN` = 1'b0, `GR_AUTO` = 1'b1;
  - direction constants: `DIR_UP` = 1, `DIR_DN` = 0.
- One sub-module, `rate_timer`:
  - parameterised by `TICK_DIV` and `TW`;
  - inputs: `clk`, `reset`, `en`; output: `tick`, a one-cycle pulse at terminal count;
  - clears to 0 when `en` = 0.
- Slots, arbiter and FSM stay in the top of `step_scheduler`.

Test Plan (`TICK_DIV` = 4, `TW` = 3):
- Reset: hold `reset`=0 for 3 cycles with `man_p` pulsing → `inc_p`, `UHDL`, `running`, `dropped` all 0 throughout; first pulse only after release.
- Single manual step: `man_p`=1 with `man_dir`=1 at edge 10 → `inc_p`=1 and `UHDL`=1 in cycle 11 only; `inc_p`=0 in cycle 12.
- Auto run:
  - `run_p` at edge 0, `auto_dir`=0 → `running`=1 from cycle 1;
  - `inc_p` pulses with `UHDL`=0 at cycles 5, 9, 13;
  - `run_p` at edge 14 → no further pulses.
- Contention:
  - manual (dir 1) and auto (dir 0) requests captured on the same edge with `last_grant`=AUTO → manual pulse first, auto pulse 2 cycles later;
  - repeat with `last_grant`=MAN → auto first.
- Overflow: three `man_p` pulses on consecutive edges while cooldown blocks issue → two pulses issued, one request lost, `dropped`=1 and stays 1 until reset.
- Reset mid-operation: both slots full and RUN active, then `reset`=0 for one edge → no pulse emitted, `running`=0, timer restarts from 0 after `run_p`.
